// File: rtl/decode_stage.sv
// Decode stage: turns a raw RV instruction word into a registered decoded bundle
// behind a valid/ready handshake. Define DECODE_STAGE_SKID_EN to add a one-entry skid buffer.
package types;
  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE,
    INVALID_TYPE
  } inst_format_e;
endpackage

module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [31:0]         inst_i,
  input  logic [XLEN-1:0]     pc_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     pc_o,
  output types::inst_format_e format_o,
  output logic [6:0]          opcode_o,
  output logic [2:0]          funct3_o,
  output logic [6:0]          funct7_o,
  output logic [4:0]          rs1_o,
  output logic [4:0]          rs2_o,
  output logic [4:0]          rd_o,
  output logic [XLEN-1:0]     imm_o,
  output logic                illegal_o
);
  import types::*;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    inst_format_e    fmt;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } bundle_t;

  localparam bundle_t BUNDLE_RESET = '{
    pc: '0, fmt: INVALID_TYPE, opcode: '0, funct3: '0, funct7: '0,
    rs1: '0, rs2: '0, rd: '0, imm: '0, illegal: 1'b0
  };

  bundle_t     dec;
  logic [31:0] imm32;
  bundle_t     out_q;
  logic        valid_q;
  logic        accept;

  always_comb begin
    // NOTE: every variable gets a default before the case statements so no path infers a latch.
    dec        = BUNDLE_RESET;
    imm32      = '0;
    dec.pc     = pc_i;
    dec.opcode = inst_i[6:0];
    dec.funct3 = inst_i[14:12];
    dec.funct7 = inst_i[31:25];
    dec.rs1    = inst_i[19:15];
    dec.rs2    = inst_i[24:20];
    dec.rd     = inst_i[11:7];

    case (inst_i[6:0])
      7'b0110011:                                           dec.fmt = R_TYPE;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0001111,
      7'b1110011:                                           dec.fmt = I_TYPE;
      7'b0100011:                                           dec.fmt = S_TYPE;
      7'b1100011:                                           dec.fmt = B_TYPE;
      7'b0110111, 7'b0010111:                               dec.fmt = U_TYPE;
      7'b1101111:                                           dec.fmt = J_TYPE;
      default:                                              dec.fmt = INVALID_TYPE;
    endcase

    case (dec.fmt)
      I_TYPE:  imm32 = {{20{inst_i[31]}}, inst_i[31:20]};
      S_TYPE:  imm32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      B_TYPE:  imm32 = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                        inst_i[11:8], 1'b0};
      U_TYPE:  imm32 = {inst_i[31:12], 12'b0};
      J_TYPE:  imm32 = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                        inst_i[30:21], 1'b0};
      default: imm32 = '0;
    endcase

    // Register fields a format does not encode are forced to zero.
    if (dec.fmt inside {I_TYPE, U_TYPE, J_TYPE, INVALID_TYPE}) dec.rs2 = '0;
    if (dec.fmt inside {U_TYPE, J_TYPE, INVALID_TYPE})         dec.rs1 = '0;
    if (dec.fmt inside {S_TYPE, B_TYPE, INVALID_TYPE})         dec.rd  = '0;

    dec.imm     = XLEN'($signed(imm32));
    dec.illegal = (dec.fmt == INVALID_TYPE) || (inst_i[1:0] != 2'b11);
  end

  assign accept = valid_i && ready_o;

`ifdef DECODE_STAGE_SKID_EN
  bundle_t skid_q;
  logic    skid_valid_q;

  // Registered ready: a stalled output still absorbs one more instruction into the skid.
  assign ready_o = !skid_valid_q;

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= BUNDLE_RESET;
    end else if (flush_i) begin
      valid_q      <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (!valid_q || ready_i) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        valid_q      <= 1'b1;
        skid_valid_q <= 1'b0;
      end else begin
        valid_q <= accept;
        if (accept) out_q <= dec;
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
    end
  end

  // NOTE: the skid payload is qualified by skid_valid_q, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && valid_q && !ready_i && accept) skid_q <= dec;
  end
`else
  assign ready_o = !valid_q || ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      out_q   <= BUNDLE_RESET;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (ready_o) begin
      valid_q <= valid_i;
      if (valid_i) out_q <= dec;
    end
  end
`endif

  assign valid_o   = valid_q;
  assign pc_o      = out_q.pc;
  assign format_o  = out_q.fmt;
  assign opcode_o  = out_q.opcode;
  assign funct3_o  = out_q.funct3;
  assign funct7_o  = out_q.funct7;
  assign rs1_o     = out_q.rs1;
  assign rs2_o     = out_q.rs2;
  assign rd_o      = out_q.rd;
  assign imm_o     = out_q.imm;
  assign illegal_o = out_q.illegal;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of pc and immediate; legal values 32 and 64.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port flush_i  input  1  discard all held and incoming instructions.
REQ-005 SHALL have port valid_i  input  1  upstream instruction valid.
REQ-006 SHALL have port ready_o  output  1  stage can accept an instruction.
REQ-007 SHALL have port inst_i  input  32  raw instruction word.
REQ-008 SHALL have port pc_i  input  XLEN  instruction address.
REQ-009 SHALL have port valid_o  output  1  decoded bundle valid.
REQ-010 SHALL have port ready_i  input  1  downstream accepts bundle.
REQ-011 SHALL have outputs pc_o (XLEN), format_o (types::inst_format_e), opcode_o (7), funct3_o (3), funct7_o (7), rs1_o/rs2_o/rd_o (5 each), imm_o (XLEN), illegal_o (1) -- registered decoded bundle.

Function
REQ-012 SHALL map opcode: 0110011 R_TYPE; 0010011, 0000011, 1100111, 0001111, 1110011 I_TYPE; 0100011 S_TYPE; 1100011 B_TYPE; 0110111, 0010111 U_TYPE; 1101111 J_TYPE; all others INVALID_TYPE.
REQ-013 SHALL form imm_o sign-extended from inst_i[31] to XLEN: I {31:20}; S {31:25,11:7}; B {31,7,30:25,11:8,0}; U {31:12,12'b0}; J {31,19:12,20,30:21,0}; INVALID zero.
REQ-014 SHALL zero rs2_o for I/U/J/INVALID, rs1_o for U/J/INVALID, rd_o for S/B/INVALID.
REQ-015 SHALL assert illegal_o when format is INVALID_TYPE or inst_i[1:0] != 2'b11; such instructions still pass through the handshake.
REQ-016 SHALL accept a transfer when valid_i && ready_o; decoded bundle appears with valid_o=1 exactly one cycle later.
REQ-017 SHALL hold the whole output bundle stable while valid_o && !ready_i.
REQ-018 SHALL complete an output transfer when valid_o && ready_i; sustain one instruction per cycle when ready_i stays high.
REQ-019 SHALL, on flush_i, clear valid_o and all buffered entries next cycle; flush_i wins over a simultaneous accept; ready_o behaviour unaffected in the flush cycle.
REQ-020 SHALL never drop or duplicate an accepted instruction absent flush or reset.

Reset
REQ-021 SHALL, on rst_i high at a clock edge, set valid_o=0, buffers empty, all bundle outputs zero, format_o INVALID_TYPE, illegal_o=0.
REQ-022 SHALL drive ready_o=1 in the first cycle after reset deasserts.
REQ-023 SHALL give rst_i priority over flush_i, valid_i and ready_i, including mid-backpressure.

Configuration
REQ-024 SHALL honour macro DECODE_STAGE_SKID_EN.
REQ-025 Without DECODE_STAGE_SKID_EN: single output register; ready_o = !valid_o || ready_i (combinational path from ready_i).
REQ-026 With DECODE_STAGE_SKID_EN: one-entry skid buffer; ready_o is a register output equal to "skid empty"; on backpressure one further instruction is captured into skid, then ready_o=0; skid drains to output before new accepts; full throughput preserved; no combinational ready_i->ready_o path.

Verification
REQ-027 inst_i=0xFFF00093 (addi x1,x0,-1), ready_i=1 -> next cycle valid_o=1, I_TYPE, rd_o=1, rs1_o=0, rs2_o=0, imm_o=0xFFFFFFFF.
REQ-028 inst_i=0x0020A423 then 0xFE000EE3 back-to-back -> S_TYPE imm_o=8 rd_o=0, then B_TYPE imm_o=0xFFFFFFFC, valid_o high two consecutive cycles.
REQ-029 ready_i=0 for 3 cycles with valid_i=1 -> bundle unchanged; no skid: ready_o=0 throughout; skid: second instruction captured, ready_o=0 from next cycle, both delivered in order once ready_i=1.
REQ-030 flush_i=1 with valid_i=1 and a held output -> valid_o=0 next cycle, neither instruction appears afterwards.
REQ-031 inst_i=0x0000007F -> INVALID_TYPE, illegal_o=1, imm_o=0; inst_i=0x00000090 -> illegal_o=1.
REQ-032 XLEN=64, inst_i=0x800002B7 (lui x5) -> U_TYPE, rd_o=5, imm_o=0xFFFFFFFF80000000; rst_i mid-stall -> valid_o=0 next cycle.
